// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers 640x480 timing from hsync/vsync, locks after consistent frames, flywheels x/y
// Ports:
//   clk_100MHz, reset_n (sync, active-low), p_tick (pixel enable)
//   hsync, vsync    : active-high sync inputs
//   x, y            : recovered pixel column / line
//   video_on        : locked && x<HD && y<VD
//   locked          : timing locked
//   frame_start     : one-clk pulse when x and y wrap to 0 while locked
//   timing_err      : one-clk pulse on period mismatch or hsync timeout while acquiring/locked
//   h_period/v_period: last measured line/frame length, built only with VGA_DEC_MEASURE_EN
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int HD          = 640,
  parameter int HTOTAL      = 800,
  parameter int VD          = 480,
  parameter int VTOTAL      = 525,
  parameter int H_SYNC_POS  = 656,
  parameter int V_SYNC_POS  = 513,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [10:0] h_period,
  output logic [10:0] v_period
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t      state, state_n;
  logic [3:0]  good, good_n;
  logic        hs_q, vs_q, first_h;
  logic [10:0] h_cnt, v_cnt;
  logic        h_rise, v_rise, h_mis, v_mis, h_to, err, x_wrap, y_wrap;
  assign h_rise = p_tick & hsync & ~hs_q;
  assign v_rise = p_tick & vsync & ~vs_q;
  assign h_mis  = h_rise & ~first_h & (h_cnt + 11'd1 != 11'(HTOTAL));
  assign v_mis  = v_rise & (v_cnt != 11'(VTOTAL));
  // timeout fires on the tick where h_cnt reaches saturation, 2047 ticks after the last h_rise
  assign h_to   = p_tick & ~h_rise & (h_cnt == 11'd2046);
  assign err    = (state != SEARCH) & (h_mis | v_mis | h_to);
  assign x_wrap = p_tick & ~h_rise & (x == 10'(HTOTAL - 1));
  assign y_wrap = x_wrap & ~v_rise & (y == 10'(VTOTAL - 1));
  assign locked   = state == LOCKED;
  assign video_on = locked && x < 10'(HD) && y < 10'(VD);
  always_comb begin
    state_n = state;
    good_n  = good;
    if (err) begin
      state_n = SEARCH;
      good_n  = '0;
    end else if (v_rise && state == SEARCH) begin
      state_n = ACQUIRE;
      good_n  = '0;
    end else if (v_rise && state == ACQUIRE) begin
      good_n  = good + 4'd1;
      state_n = (good_n == 4'(LOCK_FRAMES)) ? LOCKED : ACQUIRE;
    end
  end
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state       <= SEARCH;
      good        <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      first_h     <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      timing_err  <= err;
      frame_start <= y_wrap & locked;
      // any error drops to SEARCH, where the next line edge must go uncompared
      first_h     <= err | (first_h & ~h_rise);
      if (p_tick) begin
        hs_q  <= hsync;
        vs_q  <= vsync;
        h_cnt <= h_rise ? 11'd0 : (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
        v_cnt <= v_rise ? 11'd0 : (h_rise && v_cnt != 11'h7FF) ? v_cnt + 11'd1 : v_cnt;
        x     <= h_rise ? 10'(H_SYNC_POS) : x_wrap ? 10'd0 : x + 10'd1;
        y     <= v_rise ? 10'(V_SYNC_POS) : !x_wrap ? y : y_wrap ? 10'd0 : y + 10'd1;
      end
    end
  end
`ifdef VGA_DEC_MEASURE_EN
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      h_period <= '0;
      v_period <= '0;
    end else begin
      if (h_rise) h_period <= h_cnt + 11'd1;
      if (v_rise) v_period <= v_cnt;
    end
  end
`else
  assign h_period = '0;
  assign v_period = '0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, tracking, errors, timeout and reset on a scaled-down raster
`timescale 1ns/1ps
module tb_vga_sync_decoder;
  localparam int HD = 16, HT = 20, VD = 12, VT = 15, HS = 17, VS = 13;
  logic clk_100MHz = 1'b0, reset_n = 1'b0, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0]  x, y;
  logic        video_on, locked, frame_start, timing_err;
  logic [10:0] h_period, v_period;
  int checks = 0, errors = 0;
  int sx = 0, sy = 0, last_sx = 0, last_sy = 0, vr = 0;
  int short_line = -1, n = 0, te0 = 0, fs0 = 0, te_early = 0;
  logic short_frame = 1'b0, hold_low = 1'b0, prev_vs = 1'b0, te_now = 1'b0, fs_now = 1'b0;
  int te_cyc = 0, fs_cyc = 0;
  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) begin
    te_cyc <= te_cyc + (timing_err ? 1 : 0);
    fs_cyc <= fs_cyc + (frame_start ? 1 : 0);
  end
  vga_sync_decoder #(
    .HD(HD), .HTOTAL(HT), .VD(VD), .VTOTAL(VT),
    .H_SYNC_POS(HS), .V_SYNC_POS(VS), .LOCK_FRAMES(2)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .x(x), .y(y), .video_on(video_on),
    .locked(locked), .frame_start(frame_start), .timing_err(timing_err),
    .h_period(h_period), .v_period(v_period)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask
  // one pixel tick every four clocks; outputs sampled one clk after the tick edge
  task automatic step();
    @(negedge clk_100MHz);
    hsync = !hold_low && sx >= HS && sx < HS + 2;
    vsync = !hold_low && (sy == VS || sy == VS + 1);
    if (vsync && !prev_vs) vr++;
    prev_vs = vsync;
    last_sx = sx;
    last_sy = sy;
    p_tick  = 1'b1;
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    te_now = timing_err;
    fs_now = frame_start;
    if (sx == ((sy == short_line) ? HT - 2 : HT - 1)) begin
      sx = 0;
      if (sy == (short_frame ? VT - 2 : VT - 1)) begin
        sy = 0;
        short_frame = 1'b0;
      end else sy++;
    end else sx++;
    repeat (2) @(negedge clk_100MHz);
  endtask
  task automatic run_to_lock(input string tag);
    int vr0, k;
    vr0 = vr;
    k = 0;
    while (!locked && k < 2000) begin
      step();
      k++;
    end
    chk({tag, "_locked"}, 32'(locked), 1);
    chk({tag, "_vrises"}, 32'(vr - vr0), 3);
    chk({tag, "_at_vrise"}, 32'(last_sx == 0 && last_sy == VS), 1);
  endtask
  task automatic pulse_reset();
    @(negedge clk_100MHz);
    reset_n = 1'b0;
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    prev_vs = 1'b0;
    vr = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk_100MHz);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_video_on", 32'(video_on), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_timing_err", 32'(timing_err), 0);
    chk("rst_h_period", 32'(h_period), 0);
    chk("rst_v_period", 32'(v_period), 0);
    reset_n = 1'b1;
    run_to_lock("lock1");
`ifdef VGA_DEC_MEASURE_EN
    chk("h_period", 32'(h_period), HT);
    chk("v_period", 32'(v_period), VT);
`else
    chk("h_period", 32'(h_period), 0);
    chk("v_period", 32'(v_period), 0);
`endif
    te0 = te_cyc;
    fs0 = fs_cyc;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      chk("track_x", 32'(x), 32'(last_sx));
      chk("track_y", 32'(y), 32'(last_sy));
      chk("track_video_on", 32'(video_on), 32'(last_sx < HD && last_sy < VD));
      chk("track_frame_start", 32'(fs_now), 32'(last_sx == 0 && last_sy == 0));
      chk("track_locked", 32'(locked), 1);
    end
    chk("track_fs_count", 32'(fs_cyc - fs0), 1);
    chk("track_te_count", 32'(te_cyc - te0), 0);
    short_line = 5;
    te0 = te_cyc;
    n = 0;
    do begin
      step();
      n++;
    end while (!te_now && n < 400);
    short_line = -1;
    chk("short_te", 32'(te_now), 1);
    chk("short_unlock", 32'(locked), 0);
    chk("short_where", 32'(last_sy * HT + last_sx), 6 * HT + HS);
    repeat (2) step();
    chk("short_te_once", 32'(te_cyc - te0), 1);
    run_to_lock("relock1");
    n = 0;
    do begin
      step();
      n++;
    end while (!(last_sx == HS && last_sy == 3) && n < 400);
    chk("timeout_pre_locked", 32'(locked), 1);
    hold_low = 1'b1;
    te_early = 0;
    for (int k = 1; k < 2047; k++) begin
      step();
      te_early += te_now ? 1 : 0;
    end
    chk("timeout_early", 32'(te_early), 0);
    step();
    chk("timeout_te", 32'(te_now), 1);
    chk("timeout_unlock", 32'(locked), 0);
    hold_low = 1'b0;
    run_to_lock("relock2");
    n = 0;
    do begin
      step();
      n++;
    end while (!(last_sx == 5 && last_sy == 7) && n < 400);
    chk("midrst_pre_locked", 32'(locked), 1);
    pulse_reset();
    chk("midrst_x", 32'(x), 0);
    chk("midrst_y", 32'(y), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_video_on", 32'(video_on), 0);
    chk("midrst_timing_err", 32'(timing_err), 0);
    chk("midrst_frame_start", 32'(frame_start), 0);
    run_to_lock("lock2");
    pulse_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (vr < 1 && n < 400);
    chk("acq_not_locked", 32'(locked), 0);
    short_frame = 1'b1;
    te0 = te_cyc;
    n = 0;
    do begin
      step();
      n++;
    end while (!te_now && n < 400);
    chk("frame524_te", 32'(te_now), 1);
    chk("frame524_at_vrise", 32'(last_sx == 0 && last_sy == VS), 1);
    chk("frame524_locked", 32'(locked), 0);
`ifdef VGA_DEC_MEASURE_EN
    chk("frame524_v_period", 32'(v_period), VT - 1);
`else
    chk("frame524_v_period", 32'(v_period), 0);
`endif
    repeat (2) step();
    chk("frame524_te_once", 32'(te_cyc - te0), 1);
    run_to_lock("relock3");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
